// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcode and FSM state types shared by the multi-cycle ALU.
// The opcode encoding is fixed; opcodes 12..15 are illegal.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_ROL  = 4'd8,
        OP_ROR  = 4'd9,
        OP_SLTU = 4'd10,
        OP_MUL  = 4'd11
    } opcode_t;

    // Number of defined opcodes; anything at or above this is illegal.
    localparam int unsigned OP_COUNT = 12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mc_mul.sv
// alu_mc_mul: iterative unsigned shift-add multiplier.
// A start pulse loads the operands; exactly WIDTH iterations follow, one per
// clock, and done pulses for one cycle once the full 2*WIDTH product is ready.
module alu_mc_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;
    logic               running;
    logic [WIDTH:0]     partial;

    // Upper half plus multiplicand when the current multiplier bit is set;
    // the extra bit keeps the carry that is shifted back into the upper half.
    always_comb begin
        partial = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end
    end

    // Multiplier sits in the low half of acc and is consumed one bit per
    // iteration while the product grows in from the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc     <= '0;
            count   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand   <= a;
                acc     <= {{WIDTH{1'b0}}, b};
                count   <= '0;
                running <= 1'b1;
            end else if (running) begin
                acc   <= {partial, acc[WIDTH-1:1]};
                count <= count + 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle opcodes complete one edge after acceptance; MUL (only when
// ALU_MC_MUL_EN is defined) goes through BUSY for WIDTH iterations.
// Without ALU_MC_MUL_EN opcode 11 is illegal and result_hi is tied to 0.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry_out,
    output logic             zero,
    output logic             err
);

    state_t           state;
    opcode_t          op;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_err;
    logic             alu_zero;
    logic [WIDTH:0]   ext;
    logic             go_busy;

    assign op       = opcode_t'(sel);
    assign in_ready = (state == S_IDLE);
    assign alu_zero = (alu_res == '0);

`ifdef ALU_MC_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign go_busy   = (op == OP_MUL);
    assign mul_start = (state == S_IDLE) && in_valid && go_busy;

    alu_mc_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign go_busy   = 1'b0;
    assign result_hi = '0;
`endif

    // Single-cycle datapath evaluated on the live operands at acceptance.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        ext       = '0;
        case (op)
            OP_ADD: begin
                ext       = {1'b0, a} + {1'b0, b};
                alu_res   = ext[WIDTH-1:0];
                alu_carry = ext[WIDTH];
            end
            OP_SUB: begin
                ext       = {1'b0, a} - {1'b0, b};
                alu_res   = ext[WIDTH-1:0];
                alu_carry = ext[WIDTH];
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOT:  alu_res = ~a;
            OP_SHL: begin
                alu_res   = {a[WIDTH-2:0], 1'b0};
                alu_carry = a[WIDTH-1];
            end
            OP_SHR: begin
                alu_res   = {1'b0, a[WIDTH-1:1]};
                alu_carry = a[0];
            end
            OP_ROL: begin
                alu_res   = {a[WIDTH-2:0], a[WIDTH-1]};
                alu_carry = a[WIDTH-1];
            end
            OP_ROR: begin
                alu_res   = {a[0], a[WIDTH-1:1]};
                alu_carry = a[0];
            end
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MUL: begin
`ifndef ALU_MC_MUL_EN
                alu_err = 1'b1;
`endif
            end
            default: alu_err = 1'b1;
        endcase
    end

    // Control FSM with registered result outputs held until the consumer
    // handshakes; the handshake edge itself never accepts a new request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            err       <= 1'b0;
`ifdef ALU_MC_MUL_EN
            result_hi <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (go_busy) begin
                            state <= S_BUSY;
                        end else begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            carry_out <= alu_carry;
                            zero      <= alu_zero;
                            err       <= alu_err;
`ifdef ALU_MC_MUL_EN
                            result_hi <= '0;
`endif
                        end
                    end
                end
                S_BUSY: begin
`ifdef ALU_MC_MUL_EN
                    if (mul_done) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= mul_prod[WIDTH-1:0];
                        result_hi <= mul_prod[2*WIDTH-1:WIDTH];
                        carry_out <= 1'b0;
                        zero      <= (mul_prod == '0);
                        err       <= 1'b0;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
